// File: rtl/bist_sram_responder_if.sv
// BIST-to-SRAM access bus: the BIST drives chip enable, byte write enables, address and write data;
// the memory returns registered read data.
interface bist_sram_responder_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              cen;
    logic [BE_W-1:0]   wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;

    modport master (output cen, wen, addr, mem_datain, input mem_dataout);
    modport slave  (input cen, wen, addr, mem_datain, output mem_dataout);
endinterface

// File: rtl/bist_sram_responder.sv
// Behavioural word SRAM with byte enables, 1-cycle registered read, fault injection
// (stuck-at-0/1, transition coupling) and saturating access counters for BIST bring-up.
module bist_sram_responder #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int DEPTH  = 8192,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    bist_sram_responder_if.slave bus,
    input  logic [1:0]        flt_type,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [4:0]        flt_bit,
    input  logic [ADDR_W-1:0] flt_aggr_addr,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              oob_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0] FLT_SA0 = 2'd1;
    localparam logic [1:0] FLT_SA1 = 2'd2;
    localparam logic [1:0] FLT_CPL = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] dataout_reg, dataout_next;
    logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;
    logic              oob_reg, oob_next;

    logic              acc, is_wr, is_rd, addr_ok, bit_ok;
    logic              sa0_hit, sa1_hit, cpl_active, cpl_fire;
    logic [IDX_W-1:0]  idx, vidx;
    logic [DATA_W-1:0] we_bits, fmask, old_word, merged, wdata, rd_word;

    // Expand the active-low byte enables into a per-bit write mask.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        assign we_bits[8*gi +: 8] = {8{~bus.wen[gi]}};
    end

    always_comb begin
        acc      = !bus.cen;
        is_wr    = acc && (bus.wen != '1);
        is_rd    = acc && (bus.wen == '1);
        addr_ok  = {1'b0, bus.addr} < DEPTH_L;
        idx      = bus.addr[IDX_W-1:0];
        vidx     = flt_addr[IDX_W-1:0];
        bit_ok   = 32'(flt_bit) < 32'(DATA_W);
        fmask    = bit_ok ? ({{(DATA_W-1){1'b0}}, 1'b1} << flt_bit) : '0;
        old_word = mem[idx];
        merged   = (old_word & ~we_bits) | (bus.mem_datain & we_bits);

        sa0_hit  = (flt_type == FLT_SA0) && (bus.addr == flt_addr);
        sa1_hit  = (flt_type == FLT_SA1) && (bus.addr == flt_addr);

        wdata = merged;
        if (sa0_hit) wdata = merged & ~fmask;
        if (sa1_hit) wdata = merged | fmask;

        // Coupling needs distinct, in-range victim and aggressor words.
        cpl_active = (flt_type == FLT_CPL) && (flt_aggr_addr != flt_addr)
                     && ({1'b0, flt_addr} < DEPTH_L) && ({1'b0, flt_aggr_addr} < DEPTH_L);
        cpl_fire   = is_wr && addr_ok && cpl_active && (bus.addr == flt_aggr_addr)
                     && (|((old_word ^ bus.mem_datain) & we_bits & fmask));

        rd_word = addr_ok ? old_word : '0;
        if (addr_ok && sa0_hit) rd_word = rd_word & ~fmask;
        if (addr_ok && sa1_hit) rd_word = rd_word | fmask;

        dataout_next = is_rd ? rd_word : dataout_reg;
        wr_cnt_next  = (is_wr && (wr_cnt_reg != '1)) ? wr_cnt_reg + 1'b1 : wr_cnt_reg;
        rd_cnt_next  = (is_rd && (rd_cnt_reg != '1)) ? rd_cnt_reg + 1'b1 : rd_cnt_reg;
        oob_next     = oob_reg | (acc && !addr_ok);
    end

    // Array contents deliberately survive reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (is_wr && addr_ok) mem[idx] <= wdata;
            if (cpl_fire)         mem[vidx] <= mem[vidx] ^ fmask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_reg <= '0;
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            oob_reg     <= 1'b0;
        end else begin
            dataout_reg <= dataout_next;
            wr_cnt_reg  <= wr_cnt_next;
            rd_cnt_reg  <= rd_cnt_next;
            oob_reg     <= oob_next;
        end
    end

    assign bus.mem_dataout = dataout_reg;
    assign wr_cnt          = wr_cnt_reg;
    assign rd_cnt          = rd_cnt_reg;
    assign oob_err         = oob_reg;
endmodule
